alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request strobe; sampled on each rising edge of clk.
REQ-005 SHALL have port SrcA  input  WIDTH  first operand (dividend, multiplicand).
REQ-006 SHALL have port SrcB  input  WIDTH  second operand (divisor, multiplier).
REQ-007 SHALL have port ALUControl  input  4  operation select.
REQ-008 SHALL have port result  output  WIDTH  registered result; holds its value until the next completion.
REQ-009 SHALL have port zero  output  1  registered; high when result == 0.
REQ-010 SHALL have port ovf  output  1  registered signed overflow for ADD/SUB; 0 for all other ops.
REQ-011 SHALL have port busy  output  1  high while an iterative op is in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL accept a request only on an edge where start=1 and busy=0; SrcA, SrcB and ALUControl SHALL be captured on that edge, and later input changes SHALL have no effect.
REQ-014 SHALL ignore start while busy=1: no capture and no effect on the operation in progress.
REQ-015 SHALL decode single-cycle ops as: 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0110 SUB; 0111 SLT (signed, result 1 or 0); 0100 SLTU (unsigned).
REQ-016 SHALL decode iterative ops as: 1000 MUL (low WIDTH bits of the unsigned product); 1001 MULHU (high WIDTH bits); 1010 DIVU (quotient); 1011 REMU (remainder).
REQ-017 SHALL, for any other opcode, complete as a single-cycle op with result=0, zero=1, ovf=0.
REQ-018 SHALL, for a single-cycle op, update result, zero and ovf on the accepting edge and pulse done for exactly the following cycle; busy SHALL stay 0.
REQ-019 SHALL use two FSM states: IDLE (busy=0) and RUN (busy=1); reset forces IDLE.
REQ-020 SHALL, on acceptance of an iterative op, go IDLE->RUN, load an iteration counter with WIDTH, and set busy on the same edge.
REQ-021 SHALL perform in RUN one shift-add (MUL/MULHU) or restoring shift-subtract (DIVU/REMU) step per cycle and decrement the counter.
REQ-022 SHALL, on the edge that completes the WIDTH-th step, go RUN->IDLE, write result/zero, clear busy and assert done for one cycle.
REQ-023 Fixed latency: done SHALL be high in cycle N+1 for single-cycle ops and in cycle N+WIDTH for iterative ops, where N is the cycle of the accepting edge; latency SHALL not depend on operand values.
REQ-024 SHALL accept a new start on the same edge that done is high, giving back-to-back throughput.
REQ-025 SHALL, on divide by zero, return DIVU result = all ones and REMU result = SrcA, with normal latency and no error flag.
REQ-026 SHALL set ovf=1 on ADD when both operand signs match and the result sign differs; SHALL set ovf=1 on SUB when the operand signs differ and the result sign differs from SrcA's sign.
REQ-027 SHALL leave result, zero and ovf unchanged while busy=1; they change only on a completion edge.

Reset
REQ-028 SHALL, while reset=1 at a rising edge, set result=0, zero=1, ovf=0, busy=0, done=0, state=IDLE and counter=0.
REQ-029 SHALL abort any RUN operation on reset, with no done pulse; reset SHALL take priority over start on the same edge.

Verification (WIDTH=32)
REQ-030 ADD 0x7FFFFFFF + 1 -> result 0x80000000, ovf=1, zero=0, done exactly 1 cycle after start, busy never 1.
REQ-031 SUB 5 - 5 -> result 0, zero=1, ovf=0; SLT 0xFFFFFFFF vs 1 -> result 1; SLTU with the same operands -> result 0.
REQ-032 MUL 0xFFFFFFFF * 0xFFFFFFFF -> result 0x00000001; MULHU with the same operands -> result 0xFFFFFFFE; done 32 cycles after start, busy high cycles 1..31 after start.
REQ-033 DIVU 100 / 7 -> result 14; REMU 100 % 7 -> result 2; DIVU 9 / 0 -> result 0xFFFFFFFF; REMU 9 % 0 -> result 9.
REQ-034 MUL start, then start pulsed again with different operands mid-RUN -> second request ignored, result is the first product; a new start on the done cycle is accepted.
REQ-035 reset asserted 10 cycles into a DIVU -> next cycle busy=0, done=0, result=0, zero=1; a following ADD 2+3 -> result 5.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative shift-add multiplier and restoring divider
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op;
  logic [WIDTH-1:0] acc, q, opb;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, iter;
  logic [1:0]       op_sel;
  logic             mul;
  logic [WIDTH-1:0] src_acc, src_q, src_b;
  logic [WIDTH:0]   msum, rs;
  logic [WIDTH-1:0] dsub;
  logic             ge;
  logic [WIDTH-1:0] nacc, nq, fin_res;
  assign busy = state == RUN;
  // Single-cycle ALU result and signed overflow, computed straight from the live inputs
  always_comb begin
    sum     = SrcA + SrcB;
    diff    = SrcA - SrcB;
    iter    = ALUControl[3:2] == 2'b10;
    alu_ovf = 1'b0;
    case (ALUControl)
      4'b0000: alu_res = SrcA & SrcB;
      4'b0001: alu_res = SrcA | SrcB;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      4'b0011: alu_res = SrcA ^ SrcB;
      4'b0110: begin
        alu_res = diff;
        alu_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
      end
      4'b0111: alu_res = WIDTH'($signed(SrcA) < $signed(SrcB));
      4'b0100: alu_res = WIDTH'(SrcA < SrcB);
      default: alu_res = '0;
    endcase
  end
  // One multiply/divide step; while idle it works on the inputs so the accepting edge does step one
  always_comb begin
    op_sel  = busy ? op : ALUControl[1:0];
    mul     = ~op_sel[1];
    src_acc = busy ? acc : '0;
    src_q   = busy ? q : (mul ? SrcB : SrcA);
    src_b   = busy ? opb : (mul ? SrcA : SrcB);
    msum    = {1'b0, src_acc} + {1'b0, src_q[0] ? src_b : '0};
    rs      = {src_acc, src_q[WIDTH-1]};
    ge      = rs >= {1'b0, src_b};
    dsub    = rs[WIDTH-1:0] - src_b;
    nacc    = mul ? msum[WIDTH:1] : (ge ? dsub : rs[WIDTH-1:0]);
    nq      = mul ? {msum[0], src_q[WIDTH-1:1]} : {src_q[WIDTH-2:0], ge};
    fin_res = op_sel[0] ? nacc : nq;
  end
  // Request acceptance, iteration sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      acc    <= '0;
      q      <= '0;
      opb    <= '0;
      result <= '0;
      zero   <= 1'b1;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && iter) begin
          state <= RUN;
          cnt   <= CW'(WIDTH);
          op    <= ALUControl[1:0];
          acc   <= nacc;
          q     <= nq;
          opb   <= src_b;
        end else if (start) begin
          result <= alu_res;
          zero   <= alu_res == '0;
          ovf    <= alu_ovf;
          done   <= 1'b1;
        end
      end else begin
        acc <= nacc;
        q   <= nq;
        if (cnt == CW'(2)) begin
          state  <= IDLE;
          cnt    <= '0;
          result <= fin_res;
          zero   <= fin_res == '0;
          ovf    <= 1'b0;
          done   <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed checks of the ALU/MDU ops, latency, start handling and reset abort
module tb_alu_mdu;
  localparam int W = 32;
  logic clk = 0, reset = 1, start = 0;
  logic [W-1:0] SrcA = '0, SrcB = '0;
  logic [3:0] ALUControl = '0;
  logic [W-1:0] result;
  logic zero, ovf, busy, done;
  int passed = 0, total = 0;
  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         v;
  } vec_t;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .result(result), .zero(zero), .ovf(ovf),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ALUControl = op; SrcA = a; SrcB = b; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(output int lat, output bit bz);
    lat = 1; bz = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) bz = 0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    start = 1; ALUControl = 4'h2; SrcA = 1; SrcB = 1;
    repeat (2) @(negedge clk);
    start = 0; reset = 0;
    total++; if ({result, zero, ovf, busy, done} !== {32'h0, 4'b1000}) $display("FAIL reset: res=%h z=%b o=%b b=%b d=%b", result, zero, ovf, busy, done); else passed++;
  endtask

  task automatic test_alu;
    vec_t tbl [11];
    int lat; bit bz;
    tbl = '{
      '{4'h2, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1},
      '{4'h6, 32'h5,        32'h5,        32'h0,        1'b0},
      '{4'h7, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0},
      '{4'h4, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0},
      '{4'h0, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0},
      '{4'h1, 32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 1'b0},
      '{4'h3, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0},
      '{4'h6, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1},
      '{4'h2, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0},
      '{4'h5, 32'h3,        32'h4,        32'h0,        1'b0},
      '{4'hF, 32'h3,        32'h4,        32'h0,        1'b0}
    };
    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done(lat, bz);
      total++; if (lat !== 1 || busy !== 1'b0) $display("FAIL alu%0d latency: lat=%0d busy=%b want lat=1 busy=0", i, lat, busy); else passed++;
      total++; if (result !== tbl[i].r || zero !== (tbl[i].r == 0) || ovf !== tbl[i].v)
        $display("FAIL alu%0d op=%h: res=%h z=%b o=%b want res=%h z=%b o=%b", i, tbl[i].op, result, zero, ovf, tbl[i].r, tbl[i].r == 0, tbl[i].v); else passed++;
      if (i == 0) begin
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h80000000) $display("FAIL alu pulse: done=%b busy=%b res=%h want 0 0 80000000", done, busy, result); else passed++;
      end
    end
  endtask

  task automatic test_mdu;
    vec_t tbl [10];
    int lat; bit bz;
    tbl = '{
      '{4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0},
      '{4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
      '{4'hA, 32'd100,      32'd7,        32'd14,       1'b0},
      '{4'hB, 32'd100,      32'd7,        32'd2,        1'b0},
      '{4'hA, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0},
      '{4'hB, 32'd9,        32'd0,        32'd9,        1'b0},
      '{4'h8, 32'h00012345, 32'h00000100, 32'h01234500, 1'b0},
      '{4'h9, 32'h80000000, 32'h4,        32'h2,        1'b0},
      '{4'hA, 32'd7,        32'd100,      32'd0,        1'b0},
      '{4'hA, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0}
    };
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done(lat, bz);
      total++; if (lat !== 32 || !bz || busy !== 1'b0) $display("FAIL mdu%0d latency: lat=%0d busy_held=%b busy=%b want 32 1 0", i, lat, bz, busy); else passed++;
      total++; if (result !== tbl[i].r || zero !== (tbl[i].r == 0) || ovf !== 1'b0)
        $display("FAIL mdu%0d op=%h: res=%h z=%b o=%b want res=%h z=%b o=0", i, tbl[i].op, result, zero, ovf, tbl[i].r, tbl[i].r == 0); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int lat; bit bz;
    issue(4'h8, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    total++; if (result !== 32'hFFFFFFFF || busy !== 1'b1) $display("FAIL hold: res=%h busy=%b want FFFFFFFF 1", result, busy); else passed++;
    ALUControl = 4'h9; SrcA = 32'd7; SrcB = 32'd7; start = 1;
    @(negedge clk);
    start = 0; ALUControl = 4'h0; SrcA = 32'h55; SrcB = 32'h66;
    wait_done(lat, bz);
    total++; if (lat !== 27 || !bz) $display("FAIL ignore latency: lat=%0d busy_held=%b want 27 1", lat, bz); else passed++;
    total++; if (result !== 32'd15) $display("FAIL ignore result: res=%h want 0000000f", result); else passed++;
    ALUControl = 4'hA; SrcA = 32'd100; SrcB = 32'd7; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(lat, bz);
    total++; if (lat !== 32 || result !== 32'd14) $display("FAIL b2b divu: lat=%0d res=%h want 32 0000000e", lat, result); else passed++;
    ALUControl = 4'h2; SrcA = 32'd2; SrcB = 32'd2; start = 1;
    @(negedge clk);
    start = 0;
    total++; if (done !== 1'b1 || result !== 32'd4) $display("FAIL b2b add: done=%b res=%h want 1 00000004", done, result); else passed++;
  endtask

  task automatic test_reset_abort;
    int lat; bit bz;
    issue(4'hA, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1; start = 1; ALUControl = 4'h2; SrcA = 32'd1; SrcB = 32'd1;
    @(negedge clk);
    reset = 0; start = 0;
    total++; if ({result, zero, ovf, busy, done} !== {32'h0, 4'b1000}) $display("FAIL abort: res=%h z=%b o=%b b=%b d=%b want 0 1 0 0 0", result, zero, ovf, busy, done); else passed++;
    repeat (25) @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h0) $display("FAIL abort residue: done=%b busy=%b res=%h want 0 0 0", done, busy, result); else passed++;
    issue(4'h2, 32'd2, 32'd3);
    wait_done(lat, bz);
    total++; if (lat !== 1 || result !== 32'd5 || zero !== 1'b0) $display("FAIL after abort add: lat=%0d res=%h z=%b want 1 00000005 0", lat, result, zero); else passed++;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_mdu;
    test_back_to_back;
    test_reset_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
